// File: rtl/fifo_pkg.sv
// Shared types and helpers for the threshold FIFO: FSM state encoding and
// the threshold clamp applied whenever a new threshold pair is latched.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_IDLE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  // Clamp one threshold of the pair against its ceiling: the high threshold
  // is clamped to DEPTH, the low threshold to the already-clamped high one.
  function automatic int unsigned clamp_thr(input int unsigned th,
                                            input int unsigned limit);
    return (th > limit) ? limit : th;
  endfunction

endpackage

// File: rtl/fifo_thresh_if.sv
// Handshake/status bundle of the threshold FIFO. The slave side is the FIFO,
// the master side is whoever pushes, pops and programs the thresholds.
interface fifo_thresh_if #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  parameter int THR_W  = 5
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic              init;
  logic [THR_W-1:0]  th_low;
  logic [THR_W-1:0]  th_high;
  logic              PUSH;
  logic [DATA_W-1:0] DATA_IN;
  logic              POP;
  logic [DATA_W-1:0] DATA_OUT;
  logic              VALID_OUT;
  logic              FULL;
  logic              EMPTY;
  logic              ALMOST_FULL;
  logic              ALMOST_EMPTY;
  logic [CW-1:0]     COUNT;
  logic              ERR;
  logic              IDLE;

  modport slave (
    input  init, th_low, th_high, PUSH, DATA_IN, POP,
    output DATA_OUT, VALID_OUT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
           COUNT, ERR, IDLE
  );

  modport master (
    output init, th_low, th_high, PUSH, DATA_IN, POP,
    input  DATA_OUT, VALID_OUT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
           COUNT, ERR, IDLE
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, registered read port.
// Only the read register is reset; the array itself keeps its contents.
module fifo_mem #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A same-address write and read on one edge returns the old entry, which is
  // exactly what a push-while-full-with-pop needs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_thresh.sv
// Synchronous FIFO with programmable almost-empty/almost-full thresholds,
// an init/idle control FSM and a sticky overflow/underflow error flag.
//
//   state    | meaning
//   ST_RESET | held while RESET is high, leaves on first edge after release
//   ST_INIT  | thresholds latched on every edge with init=1
//   ST_IDLE  | PUSH/POP serviced; init=1 returns to ST_INIT
//   ST_ERROR | overflow/underflow seen; left only through RESET
module fifo_thresh
  import fifo_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  parameter int THR_W  = 5
) (
  input  logic        clk,
  input  logic        RESET,
  fifo_thresh_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int unsigned DEPTH_U = DEPTH;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || (2 ** THR_W) <= DEPTH) begin : g_bad_params
    $error("fifo_thresh: DEPTH must be a power of two >= 2 and 2**THR_W > DEPTH");
  end

  state_t            state;
  logic              idle_q;
  logic              err_q;
  logic [CW-1:0]     thr_lo;
  logic [CW-1:0]     thr_hi;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              valid_q;
  logic [DATA_W-1:0] rd_data;

  logic full;
  logic empty;
  logic in_idle;
  logic underflow;
  logic overflow;
  logic wr_en;
  logic rd_en;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_idle   = (state == ST_IDLE);
  assign underflow = bus.POP && empty;
  assign overflow  = bus.PUSH && full && !bus.POP;

  // A push while full is only legal when the same edge also pops; a push
  // alongside an underflowing pop is discarded.
  assign wr_en = in_idle && bus.PUSH && !underflow && (!full || bus.POP);
  assign rd_en = in_idle && bus.POP && !empty;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state  <= ST_RESET;
      idle_q <= 1'b0;
      err_q  <= 1'b0;
      thr_lo <= '0;
      thr_hi <= CW'(DEPTH);
    end else begin
      case (state)
        ST_RESET: begin
          state <= ST_INIT;
        end
        ST_INIT: begin
          if (bus.init) begin
            thr_hi <= CW'(clamp_thr(32'(bus.th_high), DEPTH_U));
            thr_lo <= CW'(clamp_thr(32'(bus.th_low),
                                    clamp_thr(32'(bus.th_high), DEPTH_U)));
          end else begin
            state  <= ST_IDLE;
            idle_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (underflow || overflow) begin
            state  <= ST_ERROR;
            idle_q <= 1'b0;
            err_q  <= 1'b1;
          end else if (bus.init) begin
            state  <= ST_INIT;
            idle_q <= 1'b0;
          end
        end
        default: begin
          state <= ST_ERROR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count   <= count + CW'(wr_en) - CW'(rd_en);
      valid_q <= rd_en;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (RESET),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.DATA_IN),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Flags depend only on registered COUNT and thresholds.
  assign bus.DATA_OUT     = rd_data;
  assign bus.VALID_OUT    = valid_q;
  assign bus.FULL         = full;
  assign bus.EMPTY        = empty;
  assign bus.ALMOST_FULL  = (count >= thr_hi);
  assign bus.ALMOST_EMPTY = (count <= thr_lo);
  assign bus.COUNT        = count;
  assign bus.ERR          = err_q;
  assign bus.IDLE         = idle_q;

endmodule

// File: tb/tb_fifo_thresh.sv
// Randomised scoreboard bench for fifo_thresh against a queue-based model
// of the FIFO rules; popped data is checked by a separate monitor.
module tb_fifo_thresh;

  localparam int DATA_W = 6;
  localparam int DEPTH  = 8;
  localparam int THR_W  = 5;

  localparam int M_RESET = 0;
  localparam int M_INIT  = 1;
  localparam int M_IDLE  = 2;
  localparam int M_ERROR = 3;

  logic clk = 1'b0;
  logic RESET = 1'b1;

  fifo_thresh_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .THR_W(THR_W)) bus ();

  fifo_thresh #(.DATA_W(DATA_W), .DEPTH(DEPTH), .THR_W(THR_W)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int m_mode;
  int m_lo;
  int m_hi;
  bit m_err;
  bit m_valid;
  int m_dout;
  int q[$];
  int exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode  = M_RESET;
    m_lo    = 0;
    m_hi    = DEPTH;
    m_err   = 1'b0;
    m_valid = 1'b0;
    m_dout  = 0;
    q.delete();
    exp_q.delete();
  endtask

  // Predicts the effect of the next rising edge given the inputs now driven.
  task automatic model_step(input bit push, input bit pop, input int data,
                            input bit init, input int thl, input int thh);
    m_valid = 1'b0;
    case (m_mode)
      M_RESET: m_mode = M_INIT;
      M_INIT: begin
        if (init) begin
          m_hi = (thh < DEPTH) ? thh : DEPTH;
          m_lo = (thl < m_hi) ? thl : m_hi;
        end else begin
          m_mode = M_IDLE;
        end
      end
      M_IDLE: begin
        if ((pop && q.size() == 0) || (push && !pop && q.size() == DEPTH)) begin
          m_err  = 1'b1;
          m_mode = M_ERROR;
        end else begin
          if (pop) begin
            m_dout = q.pop_front();
            exp_q.push_back(m_dout);
            m_valid = 1'b1;
          end
          if (push) q.push_back(data);
          if (init) m_mode = M_INIT;
        end
      end
      default: ;
    endcase
  endtask

  task automatic drive_step(input bit push, input bit pop, input int data,
                            input bit init, input int thl, input int thh);
    bus.PUSH    = push;
    bus.POP     = pop;
    bus.DATA_IN = DATA_W'(data);
    bus.init    = init;
    bus.th_low  = THR_W'(thl);
    bus.th_high = THR_W'(thh);
    model_step(push, pop, data, init, thl, thh);
  endtask

  task automatic cyc(input bit push, input bit pop, input int data,
                     input bit init, input int thl, input int thh);
    @(negedge clk);
    drive_step(push, pop, data, init, thl, thh);
  endtask

  task automatic push_w(input int data);
    cyc(1'b1, 1'b0, data, 1'b0, 0, 0);
  endtask

  task automatic pop_w();
    cyc(1'b0, 1'b1, 0, 1'b0, 0, 0);
  endtask

  task automatic idle_c();
    cyc(1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic do_init(input int thl, input int thh);
    cyc(1'b0, 1'b0, 0, 1'b1, thl, thh);
    cyc(1'b0, 1'b0, 0, 1'b1, thl, thh);
    idle_c();
  endtask

  // Asserts RESET between edges and checks the asynchronous clear before
  // any further clock edge, then releases on the following falling edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    RESET = 1'b1;
    bus.PUSH = 1'b0;
    bus.POP  = 1'b0;
    bus.init = 1'b0;
    #1;
    chk("async_count", int'(bus.COUNT), 0);
    chk("async_err", int'(bus.ERR), 0);
    chk("async_valid", int'(bus.VALID_OUT), 0);
    model_reset();
    @(negedge clk);
    RESET = 1'b0;
    drive_step(1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  // Monitor: per-cycle status compare plus scoreboard pop on VALID_OUT.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("count", int'(bus.COUNT), q.size());
      chk("full", int'(bus.FULL), int'(q.size() == DEPTH));
      chk("empty", int'(bus.EMPTY), int'(q.size() == 0));
      chk("almost_full", int'(bus.ALMOST_FULL), int'(q.size() >= m_hi));
      chk("almost_empty", int'(bus.ALMOST_EMPTY), int'(q.size() <= m_lo));
      chk("err", int'(bus.ERR), int'(m_err));
      chk("idle", int'(bus.IDLE), int'(m_mode == M_IDLE));
      chk("valid_out", int'(bus.VALID_OUT), int'(m_valid));
      chk("data_out_hold", int'(bus.DATA_OUT), m_dout);
      if (bus.VALID_OUT) begin
        if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
        else chk("pop_data", int'(bus.DATA_OUT), exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.PUSH    = 1'b0;
    bus.POP     = 1'b0;
    bus.DATA_IN = '0;
    bus.init    = 1'b0;
    bus.th_low  = '0;
    bus.th_high = '0;
    model_reset();
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    drive_step(1'b0, 1'b0, 0, 1'b0, 0, 0);

    // Reset sequence and threshold crossing with low=1, high=3.
    do_init(1, 3);
    push_w('h0A);
    push_w('h3E);
    push_w('h0F);
    pop_w();
    pop_w();
    pop_w();
    idle_c();

    // Fill, wrap and a simultaneous push/pop while full.
    for (int i = 0; i < DEPTH; i++) push_w($urandom_range(0, 63));
    for (int i = 0; i < 3; i++) pop_w();
    for (int i = 0; i < 3; i++) push_w($urandom_range(0, 63));
    cyc(1'b1, 1'b1, $urandom_range(0, 63), 1'b0, 0, 0);
    idle_c();

    // Overflow, then everything ignored in ERROR.
    push_w('h15);
    cyc(1'b1, 1'b1, 'h16, 1'b0, 0, 0);
    pop_w();
    push_w('h17);
    idle_c();

    // Underflow after reset.
    async_reset();
    do_init(1, 3);
    pop_w();
    cyc(1'b1, 1'b1, 'h2A, 1'b0, 0, 0);
    idle_c();

    // Reset in the middle of a burst.
    async_reset();
    do_init(2, 6);
    for (int i = 0; i < 5; i++) push_w($urandom_range(0, 63));
    cyc(1'b1, 1'b1, $urandom_range(0, 63), 1'b0, 0, 0);
    async_reset();

    // Clamping: high=20 -> 8, low=25 -> 8.
    do_init(25, 20);
    for (int i = 0; i < DEPTH; i++) push_w($urandom_range(0, 63));
    for (int i = 0; i < DEPTH; i++) pop_w();
    idle_c();

    // Randomised rounds with random thresholds and occasional re-init.
    for (int r = 0; r < 4; r++) begin
      async_reset();
      do_init($urandom_range(0, 31), $urandom_range(0, 31));
      for (int c = 0; c < 150; c++) begin
        bit p;
        bit o;
        p = 1'($urandom_range(0, 1));
        o = 1'($urandom_range(0, 1));
        if (o && q.size() == 0 && $urandom_range(0, 19) != 0) o = 1'b0;
        if (p && !o && q.size() == DEPTH && $urandom_range(0, 19) != 0) p = 1'b0;
        if ($urandom_range(0, 39) == 0) do_init($urandom_range(0, 31), $urandom_range(0, 31));
        else cyc(p, o, $urandom_range(0, 63), 1'b0, 0, 0);
      end
    end

    idle_c();
    idle_c();
    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
